// File: rtl/hid_report_tx.sv
// hid_report_tx: sends {HEADER,cmd,x,y[,cmd^x^y when HID_TX_CHECKSUM_EN]} as 8N1 UART on tx_pin; one-entry report slot (report_valid/report_ready), busy and dropped flags
module hid_report_tx #(
  parameter int CLK_FREQ = 25000000,
  parameter int BAUD = 9600,
  parameter int COORD_W = 6,
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         cmd_in,
  input  logic [COORD_W-1:0] x_in,
  input  logic [COORD_W-1:0] y_in,
  input  logic               report_valid,
  output logic               report_ready,
  output logic               tx_pin,
  output logic               busy,
  output logic               dropped
);
  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW = $clog2(CPB);
  localparam int RW = 8 + 2 * COORD_W;
`ifdef HID_TX_CHECKSUM_EN
  localparam logic [2:0] LAST_BYTE = 3'd4;
`else
  localparam logic [2:0] LAST_BYTE = 3'd3;
`endif
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d, byte_q, byte_d;
  logic [RW-1:0] slot_q, slot_d, frame_q, frame_d;
  logic slot_full_q, slot_full_d, tx_q, tx_d, dropped_q, dropped_d;
  logic [7:0] cmd_f, x_f, y_f, base_byte, cur_byte;
  logic last, take, accept;
  assign cmd_f = frame_q[RW-1 -: 8];
  assign x_f = 8'(frame_q[2*COORD_W-1 -: COORD_W]);
  assign y_f = 8'(frame_q[COORD_W-1:0]);
  assign base_byte = byte_q == 3'd0 ? HEADER : byte_q == 3'd1 ? cmd_f : byte_q == 3'd2 ? x_f : y_f;
`ifdef HID_TX_CHECKSUM_EN
  assign cur_byte = byte_q == 3'd4 ? cmd_f ^ x_f ^ y_f : base_byte;
`else
  assign cur_byte = base_byte;
`endif
  always_comb begin
    last = cnt_q == CW'(CPB - 1);
    take = state_q == IDLE && slot_full_q;
    accept = report_valid && !slot_full_q;
    slot_full_d = accept || (slot_full_q && !take);
    slot_d = accept ? {cmd_in, x_in, y_in} : slot_q;
    dropped_d = report_valid && slot_full_q;
    tx_d = state_q == START ? 1'b0 : state_q == DATA ? cur_byte[bit_q] : 1'b1;
    cnt_d = (state_q == IDLE || last) ? '0 : cnt_q + 1'b1;
    state_d = state_q;
    bit_d = bit_q;
    byte_d = byte_q;
    frame_d = frame_q;
    case (state_q)
      IDLE: if (slot_full_q) begin
        frame_d = slot_q;
        byte_d = '0;
        bit_d = '0;
        state_d = START;
      end
      START: if (last) state_d = DATA;
      DATA: if (last) begin
        bit_d = bit_q + 1'b1;
        if (bit_q == 3'd7) state_d = STOP;
      end
      STOP: if (last) begin
        state_d = byte_q == LAST_BYTE ? IDLE : START;
        byte_d = byte_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      byte_q <= '0;
      slot_q <= '0;
      frame_q <= '0;
      slot_full_q <= 1'b0;
      tx_q <= 1'b1;
      dropped_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      byte_q <= byte_d;
      slot_q <= slot_d;
      frame_q <= frame_d;
      slot_full_q <= slot_full_d;
      tx_q <= tx_d;
      dropped_q <= dropped_d;
    end
  end
  assign report_ready = !slot_full_q;
  assign busy = state_q != IDLE || slot_full_q;
  assign tx_pin = tx_q;
  assign dropped = dropped_q;
endmodule
